// File: rtl/crc16_check_arbiter_if.sv
// Requester/result bundle for the shared CRC-16 check engine.
// The master side drives frames and consumes results; the slave side is the arbiter.
interface crc16_check_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int FRAME_W = 39
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*FRAME_W-1:0] req_frame;
    logic [N_REQ-1:0]         req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [ID_W-1:0]          res_id;
    logic [FRAME_W-1:0]       res_frame;
    logic                     res_ok;
    logic                     busy;

    modport master (
        output req_valid, req_frame, res_ready,
        input  req_ready, res_valid, res_id, res_frame, res_ok, busy
    );

    modport slave (
        input  req_valid, req_frame, res_ready,
        output req_ready, res_valid, res_id, res_frame, res_ok, busy
    );
endinterface

// File: rtl/crc16_check_arbiter.sv
// Round-robin arbiter in front of one bit-serial CRC-16 checker; each granted frame
// is shifted MSB-first through the LFSR and reported as good/bad with its requester id.
module crc16_check_arbiter #(
    parameter int          N_REQ   = 4,
    parameter int          ID_W    = 2,
    parameter int          FRAME_W = 39,
    parameter logic [15:0] POLY    = 16'h8005
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crc16_check_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [FRAME_W-1:0] r_frame;
    logic [15:0]        r_lfsr;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_last;
    logic               r_res_valid;
    logic               r_res_ok;

    logic               w_grant_any;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_cand;
    logic               w_fb;
    logic [15:0]        w_lfsr_next;
    logic [N_REQ-1:0]   w_ready;

    // Scan from farthest to nearest so the requester closest after r_last wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(r_last) + k) % N_REQ);
            if (bus.req_valid[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_cand;
            end
        end
    end

    // Grant is only offered in IDLE and is forced low while reset is held.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign w_ready[gi] = rst_n && (r_state == S_IDLE) && w_grant_any
                                 && (w_grant_id == ID_W'(gi));
        end
    endgenerate

    assign w_fb        = r_shreg[FRAME_W-1] ^ r_lfsr[15];
    assign w_lfsr_next = {r_lfsr[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_frame     <= '0;
            r_lfsr      <= '0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_last      <= ID_W'(N_REQ - 1);
            r_res_valid <= 1'b0;
            r_res_ok    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_shreg <= bus.req_frame[w_grant_id*FRAME_W +: FRAME_W];
                        r_frame <= bus.req_frame[w_grant_id*FRAME_W +: FRAME_W];
                        r_id    <= w_grant_id;
                        r_last  <= w_grant_id;
                        r_lfsr  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    r_lfsr  <= w_lfsr_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Last frame bit: the remainder is decided by this cycle's LFSR update.
                    if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                        r_res_ok    <= (w_lfsr_next == 16'h0000);
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_id;
    assign bus.res_frame = r_frame;
    assign bus.res_ok    = r_res_ok;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_crc16_check_arbiter.sv
// Directed bench for crc16_check_arbiter: latency, CRC good/bad frames, round-robin
// order and spacing, result back-pressure, frame sampling, and mid-frame reset.
module tb_crc16_check_arbiter;
    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int FRAME_W = 39;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    crc16_check_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .FRAME_W(FRAME_W)) bus ();

    crc16_check_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .FRAME_W(FRAME_W), .POLY(16'h8005)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag);
        int k;
        k = 0;
        while (!bus.res_valid && k < 100) begin
            tick();
            k++;
        end
        check(tag, 64'(bus.res_valid), 64'd1);
    endtask

    // Single-requester frame with exact-latency and result checks, then consume.
    task automatic do_frame(input int id, input logic [FRAME_W-1:0] frame,
                            input logic exp_ok, input string tag);
        bus.req_frame[id*FRAME_W +: FRAME_W] = frame;
        bus.req_valid[id] = 1'b1;
        #1;
        check({tag, "_grant"}, 64'(bus.req_ready), 64'(4'b0001 << id));
        tick();
        bus.req_valid[id] = 1'b0;
        repeat (38) tick();
        check({tag, "_early"}, 64'(bus.res_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
        check({tag, "_id"}, 64'(bus.res_id), 64'(id));
        check({tag, "_ok"}, 64'(bus.res_ok), 64'(exp_ok));
        check({tag, "_frame"}, 64'(bus.res_frame), 64'(frame));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_idle"}, 64'({bus.res_valid, bus.busy}), 64'd0);
    endtask

    initial begin
        int prev;
        int k;
        logic seen;
        logic [3:0] exp_rdy;
        bus.req_valid = '0;
        bus.req_frame = '0;
        bus.res_ready = 1'b0;
        prev = 0;

        repeat (2) tick();
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_outs", 64'({bus.res_valid, bus.res_id, bus.res_ok, bus.busy}), 64'd0);
        check("rst_frame", 64'(bus.res_frame), 64'd0);
        rst_n = 1'b1;

        // Good/bad frames; {23'd3,16'h000A} is x*P(x), {23'd0,16'h8005} is P(x)-x^16.
        do_frame(0, 39'h0, 1'b1, "zero");
        do_frame(1, {23'd1, 16'h8005}, 1'b1, "poly");
        do_frame(1, {23'd1, 16'h8004}, 1'b0, "polyerr");
        do_frame(2, {23'd3, 16'h000A}, 1'b1, "xpoly");
        do_frame(3, {23'd0, 16'h8005}, 1'b0, "nodata");

        // All four requesting: order 0,1,2,3,0 at 41-cycle spacing.
        bus.req_frame = '0;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            k = 0;
            while (bus.req_ready == 4'b0000 && k < 60) begin
                tick();
                k++;
            end
            check($sformatf("rr_grant%0d", g), 64'(bus.req_ready), 64'(4'b0001 << (g % 4)));
            if (g > 0) check($sformatf("rr_gap%0d", g), 64'(cyc - prev), 64'd41);
            prev = cyc;
            tick();
        end
        bus.req_valid = '0;
        wait_result("rr_last_wait");
        check("rr_last_id", 64'(bus.res_id), 64'd0);
        tick();
        bus.res_ready = 1'b0;

        // Back-pressure: result held for 10 cycles, no grant while waiting.
        bus.req_frame[2*FRAME_W +: FRAME_W] = {23'd3, 16'h000A};
        bus.req_valid[2] = 1'b1;
        #1;
        check("bp_grant", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        bus.req_frame[1*FRAME_W +: FRAME_W] = 39'h0;
        bus.req_valid[1] = 1'b1;
        wait_result("bp_wait");
        for (int s = 0; s < 10; s++) begin
            check($sformatf("bp_hold%0d", s),
                  64'({bus.res_valid, bus.res_id, bus.res_ok, bus.res_frame, bus.req_ready}),
                  64'({1'b1, 2'd2, 1'b1, {23'd3, 16'h000A}, 4'b0000}));
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_release", 64'({bus.res_valid, bus.req_ready}), 64'({1'b0, 4'b0010}));
        tick();
        bus.req_valid[1] = 1'b0;
        wait_result("bp_next_wait");
        check("bp_next", 64'({bus.res_id, bus.res_ok}), 64'({2'd1, 1'b1}));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Frame changed after grant must not affect the check.
        bus.req_frame[2*FRAME_W +: FRAME_W] = 39'h0;
        bus.req_valid[2] = 1'b1;
        #1;
        check("late_grant", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        repeat (5) tick();
        bus.req_frame[2*FRAME_W +: FRAME_W] = {23'd1, 16'h8004};
        wait_result("late_wait");
        check("late_res", 64'({bus.res_id, bus.res_ok}), 64'({2'd2, 1'b1}));
        check("late_frame", 64'(bus.res_frame), 64'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Reset at SHIFT cycle 20; pointer must return to N_REQ-1 (requester 0 first).
        bus.req_frame = '0;
        bus.req_valid[1] = 1'b1;
        #1;
        check("rst2_grant", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid[1] = 1'b0;
        repeat (19) tick();
        check("rst2_busy", 64'(bus.busy), 64'd1);
        bus.req_valid = 4'b0101;
        #1;
        check("rst2_noready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst2_outs", 64'({bus.res_valid, bus.res_id, bus.res_ok, bus.busy, bus.req_ready}), 64'd0);
        check("rst2_frame", 64'(bus.res_frame), 64'd0);
        seen = 1'b0;
        repeat (45) begin
            tick();
            if (bus.res_valid) seen = 1'b1;
        end
        check("rst2_nores", 64'(seen), 64'd0);
        rst_n = 1'b1;
        #1;
        exp_rdy = 4'b0001;
        check("rst2_first", 64'(bus.req_ready), 64'(exp_rdy));
        tick();
        bus.req_valid = '0;
        wait_result("rst2_wait");
        check("rst2_res", 64'({bus.res_id, bus.res_ok}), 64'({2'd0, 1'b1}));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc16_check_arbiter.md
Name: crc16_check_arbiter

Overview:
- Shares one bit-serial CRC-16 check engine among N_REQ requesters, each presenting a complete encoded frame (data followed by a 16-bit CRC).
- Round-robin arbitration picks one requester. The block loads its frame, runs the frame MSB-first through the CRC LFSR, then presents a pass/fail result tagged with the requester id on a valid/ready result port.
- Sits between the frame sources and the receive-side consumers. It replaces per-source combinational checkers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; 2**ID_W >= N_REQ.
- FRAME_W, 39, encoded frame width (23 data bits + 16 CRC bits).
- POLY, 16'h8005, generator polynomial x^16+x^15+x^2+1, implicit x^16 term.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester frame valid.
- req_frame  in  N_REQ*FRAME_W  frames; requester i occupies bits [i*FRAME_W +: FRAME_W].
- req_ready  out  N_REQ  one-hot grant/accept; at most one bit high.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_id  out  ID_W  index of requester whose frame was checked.
- res_frame  out  FRAME_W  checked frame, unmodified.
- res_ok  out  1  1 = remainder zero (CRC good), 0 = error.
- busy  out  1  high in SHIFT and DONE.

Behaviour:
- One clock. rst_n is asynchronous, active-low.
- Reset values: state=IDLE; req_ready=0; res_valid=0; res_id=0; res_frame=0; res_ok=0; busy=0; LFSR=0; bit counter=0; rr pointer last=N_REQ-1, so requester 0 has first priority.
- IDLE state:
  - Grant is combinational: first i with req_valid[i]=1, searching last+1, last+2, ... wrapping modulo N_REQ.
  - req_ready[i]=1 for that i only, and only in IDLE.
  - Handshake on req_valid[i]&req_ready[i]: latch frame into shift register and i into id register, set last=i, clear LFSR and counter, go to SHIFT.
  - No valid requester: stay in IDLE, all req_ready=0.
- SHIFT state:
  - Each cycle takes b = shreg[FRAME_W-1] and shifts shreg left.
  - fb = b ^ lfsr[15]; lfsr = {lfsr[14:0],1'b0} ^ (fb ? POLY : 16'h0).
  - Counter increments. After exactly FRAME_W SHIFT cycles, go to DONE.
  - req_ready=0 throughout.
- DONE state:
  - res_valid=1; res_ok = (lfsr==16'h0); res_id and res_frame come from latched registers.
  - All result outputs are stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready, go to IDLE with res_valid=0.
- Latency: handshake at cycle T gives res_valid=1 at cycle T+1+FRAME_W (T+40 at default). Minimum spacing between grants is FRAME_W+2 cycles when res_ready is held high.
- Fairness: a requester that keeps req_valid high is granted within N_REQ grants.
- Requester rules: req_valid and its frame are held until req_ready. The arbiter samples the frame only on the handshake cycle; later frame changes are ignored.
- Deasserting req_valid before grant withdraws the request; no state change.
- Simultaneous requests are resolved by rr order only; there is no fixed priority after reset.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the in-flight frame is dropped and no result is emitted. The rr pointer resets to N_REQ-1.
- Width rules: counter is clog2(FRAME_W+1) bits. The LFSR is exactly 16 bits; the x^16 term is implicit.

Test Plan:
- Reset, then req_valid=4'b0001 with frame0=39'h0: req_ready=4'b0001 same cycle; 40 cycles later res_valid=1, res_id=0, res_ok=1, res_frame=39'h0.
- Requester 1 frame={23'd1,16'h8005}, res_ready=1: res_ok=1, res_id=1. Then frame={23'd1,16'h8004}: res_ok=0.
- All four req_valid high continuously, all frames 39'h0, res_ready=1: grant order 0,1,2,3,0. Consecutive req_ready pulses are 41 cycles apart.
- res_ready held 0 for 10 cycles after res_valid: res_valid, res_id, res_ok and res_frame stay constant; no req_ready in that window; IDLE only after res_ready=1.
- Requester 2 changes req_frame during SHIFT to {23'd1,16'h8004} after grant of 39'h0: result still res_ok=1 with res_frame=39'h0.
- rst_n pulsed low at SHIFT cycle 20: outputs return to reset values asynchronously and no res_valid follows. Requester 0 with req_valid high is granted first after release.
